// File: rtl/fir_pkg.sv
// Shared types and sizes for the 16-tap FIR coefficient path.
package fir_pkg;

   localparam int NTAPS = 16;
   localparam int CW    = 16;
   localparam int IDXW  = $clog2(NTAPS);

   typedef logic signed [CW-1:0] coef_t;
   typedef coef_t coef_arr_t [NTAPS];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2,
      SWAP  = 2'd3
   } coef_state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient storage: a serially written shadow bank and an
// active bank that is replaced as a whole on swap.
module fir_coef_bank
   import fir_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [IDXW-1:0] wr_idx,
   input  coef_t           wr_data,
   input  logic            swap,
   output coef_arr_t       active
);

   coef_arr_t r_shadow;
   coef_arr_t r_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            r_shadow[wr_idx] <= wr_data;
         end
         // Whole-set copy so the filter never observes a mixed old/new bank.
         if (swap) begin
            r_active <= r_shadow;
         end
      end
   end

   assign active = r_active;

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient load/commit controller: frames a serial word stream into the
// shadow bank and swaps it live on an input-sample strobe.
module fir_coef_ctrl
   import fir_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      cfg_valid,
   output logic      cfg_ready,
   input  coef_t     cfg_data,
   input  logic      cfg_last,
   input  logic      commit_req,
   input  logic      sample_en,
   output coef_arr_t coef_o,
   output logic      busy,
   output logic      swap_done,
   output logic      load_err
);

   coef_state_t     r_state;
   logic [IDXW-1:0] r_idx;
   logic            r_commit_pend;
   logic            r_load_err;

   logic            w_accept;
   logic            w_idx_last;
   logic            w_swap;

   assign cfg_ready  = (r_state == IDLE) || (r_state == LOAD);
   assign w_accept   = cfg_valid && cfg_ready;
   assign w_idx_last = (r_idx == IDXW'(NTAPS - 1));
   // Swap lands on the sample_en edge, the same edge the filter shifts in xn.
   assign w_swap     = (r_state == ARMED) && (commit_req || r_commit_pend) && sample_en;

   assign busy      = (r_state != IDLE);
   assign swap_done = (r_state == SWAP);
   assign load_err  = r_load_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_commit_pend <= 1'b0;
         r_load_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (cfg_last) begin
                     r_load_err <= 1'b1;
                     r_idx      <= '0;
                  end else begin
                     r_load_err <= 1'b0;
                     r_idx      <= r_idx + 1'b1;
                     r_state    <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (w_accept) begin
                  if (w_idx_last && cfg_last) begin
                     r_state <= ARMED;
                  end else if (w_idx_last || cfg_last) begin
                     r_load_err <= 1'b1;
                     r_idx      <= '0;
                     r_state    <= IDLE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ARMED: begin
               if (w_swap) begin
                  r_state <= SWAP;
               end else if (commit_req) begin
                  r_commit_pend <= 1'b1;
               end
            end
            SWAP: begin
               r_commit_pend <= 1'b0;
               r_idx         <= '0;
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   fir_coef_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_accept),
      .wr_idx  (r_idx),
      .wr_data (cfg_data),
      .swap    (w_swap),
      .active  (coef_o)
   );

endmodule
